activation_sequencer: RTL



---
 rtl/conv_net_pkg.sv | 32 +++
 rtl/activation_sequencer_bank.sv | 27 ++
 rtl/activation_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/conv_net_pkg.sv
// conv_net_pkg: shared types and helpers for the conv_net pipeline.
// ACTIVATION_LEAKY_EN selects a 1/8-slope leaky ReLU instead of plain ReLU.
package conv_net_pkg;

  // Lane arithmetic runs at this width; callers sign-extend in and truncate out.
  localparam int ACT_MAXW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } act_state_t;

  function automatic int act_words(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  function automatic int act_aw(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic logic signed [ACT_MAXW-1:0] act_lane(
    input logic signed [ACT_MAXW-1:0] x
  );
`ifdef ACTIVATION_LEAKY_EN
    return x[ACT_MAXW-1] ? (x >>> 3) : x;
`else
    return x[ACT_MAXW-1] ? '0 : x;
`endif
  endfunction

endpackage

// File: rtl/activation_sequencer_bank.sv
// act_lane_bank: LANES activation cells plus last-word lane masking.
// Purely combinational; sits between the S1 read word and the S2 register.
module act_lane_bank
  import conv_net_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4,
  parameter int REM      = 0
) (
  input  logic [LANES*BITWIDTH-1:0] data_i,
  input  logic                      last_i,
  output logic [LANES*BITWIDTH-1:0] data_o,
  output logic [LANES-1:0]          mask_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [BITWIDTH-1:0] x;
    logic                       en;

    assign x = data_i[l*BITWIDTH +: BITWIDTH];
    assign en = !last_i || (REM == 0) || (l < REM);
    assign mask_o[l] = en;
    assign data_o[l*BITWIDTH +: BITWIDTH] =
      en ? BITWIDTH'(act_lane(ACT_MAXW'(x))) : '0;
  end

endmodule

// File: rtl/activation_sequencer.sv
// activation_sequencer: streams a feature map through a shared ReLU bank.
// Build option ACTIVATION_LEAKY_EN switches the lanes to leaky ReLU.
module activation_sequencer
  import conv_net_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int DATACHANNEL = 3,
  parameter int DATAHEIGHT  = 28,
  parameter int DATAWIDTH   = 28,
  parameter int LANES       = 4,
  localparam int N     = DATACHANNEL * DATAHEIGHT * DATAWIDTH,
  localparam int WORDS = act_words(N, LANES),
  localparam int AW    = act_aw(WORDS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [AW-1:0]             rd_addr,
  input  logic [LANES*BITWIDTH-1:0] rd_data,
  output logic                      wr_en,
  output logic [AW-1:0]             wr_addr,
  output logic [LANES*BITWIDTH-1:0] wr_data,
  output logic [LANES-1:0]          wr_mask,
  input  logic                      wr_ready
);

  localparam int            REM  = N % LANES;
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  act_state_t state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic s1_v_q, s1_v_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [LANES*BITWIDTH-1:0] wr_data_q, wr_data_d;
  logic [LANES-1:0] wr_mask_q, wr_mask_d;
  logic done_q, done_d;

  logic adv;
  logic wr_fire;
  logic rd_go;
  logic [LANES*BITWIDTH-1:0] bank_data;
  logic [LANES-1:0] bank_mask;

  act_lane_bank #(
    .BITWIDTH(BITWIDTH),
    .LANES   (LANES),
    .REM     (REM)
  ) u_bank (
    .data_i(rd_data),
    .last_i(s1_addr_q == LAST),
    .data_o(bank_data),
    .mask_o(bank_mask)
  );

  // S2 and S1 move together whenever the output register is free.
  assign adv     = !wr_en_q || wr_ready;
  assign wr_fire = wr_en_q && wr_ready;
  assign rd_go   = (state_q == ST_RUN) && (!s1_v_q || adv);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (rd_go && rd_addr_q == LAST) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (wr_fire && wr_addr_q == LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    s1_v_d    = s1_v_q && !adv;
    s1_addr_d = s1_addr_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    if (rd_go) begin
      rd_addr_d = (rd_addr_q == LAST) ? '0 : rd_addr_q + 1'b1;
      s1_v_d    = 1'b1;
      s1_addr_d = rd_addr_q;
    end
    if (adv) begin
      wr_en_d = s1_v_q;
      if (s1_v_q) begin
        wr_addr_d = s1_addr_q;
        wr_data_d = bank_data;
        wr_mask_d = bank_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      s1_v_q    <= s1_v_d;
      s1_addr_q <= s1_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign rd_en   = rd_go;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_mask = wr_mask_q;

endmodule
